// File: rtl/arb_client_pkg.sv
// Shared types for the arbiter client requester: FSM state encoding and the
// default command word layout held in the command FIFO.
package arb_client_pkg;

  localparam int CMD_DATA_W = 8;
  localparam int CMD_LEN_W  = 4;
  localparam int CMD_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Command word as stored in the FIFO for the default widths: {len, base}.
  typedef struct packed {
    logic [CMD_LEN_W-1:0]  len;
    logic [CMD_DATA_W-1:0] base;
  } cmd_t;

endpackage

// File: rtl/req_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module req_cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_an,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  // Advance each pointer only when its side actually transfers a word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/arb_client_requester.sv
// Client side of a round-robin arbiter port: queues burst commands, holds req
// high for the duration of a burst, issues one beat per granted cycle and drops
// req for one GAP cycle between bursts so peers get their turn.
module arb_client_requester
  import arb_client_pkg::*;
#(
  parameter int DATA_W = CMD_DATA_W,
  parameter int LEN_W  = CMD_LEN_W,
  parameter int DEPTH  = CMD_DEPTH
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_base,
  output logic              req,
  input  logic              grant,
  output logic              beat_valid,
  output logic [DATA_W-1:0] beat_data,
  output logic              beat_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = LEN_W + DATA_W;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic              req_q, req_d;
  logic              done_q, done_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CW-1:0]     fifo_rd_data;
  logic [LEN_W-1:0]  head_len;
  logic [DATA_W-1:0] head_base;

  req_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_an    (rst_an),
    .push      (cmd_valid),
    .push_data ({cmd_len, cmd_base}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_len, head_base} = fifo_rd_data;

  // A grant only moves data while our registered req is high; a lagging grant
  // seen during GAP or IDLE is ignored.
  assign cmd_ready  = !fifo_full;
  assign req        = req_q;
  assign done       = done_q;
  assign beat_valid = req_q && grant;
  assign beat_data  = base_q + DATA_W'(cnt_q);
  assign beat_last  = beat_valid && (cnt_q == len_q);
  assign busy       = (state_q != IDLE) || !fifo_empty;

  // Next-state logic: load a command from IDLE or straight out of GAP, count
  // beats in REQ, and always pass through GAP after the final beat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    base_d   = base_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          len_d    = head_len;
          base_d   = head_base;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (beat_valid) begin
          if (cnt_q == len_q) state_d = GAP;
          else                cnt_d   = cnt_q + LEN_W'(1);
        end
      end
      GAP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          len_d    = head_len;
          base_d   = head_base;
          cnt_d    = '0;
          state_d  = REQ;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = (state_d == REQ);
    done_d = beat_last;
  end

  // State, burst context and registered outputs; reset aborts any burst.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

endmodule
